// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter: N cache-side request ports onto one memory bus request channel.
// Optional macro ARB_GRANT_STATS_EN adds per-requester grant counters (stat_sel/stat_count).
module bus_arbiter_rr #(
  parameter int NUM_REQ        = 2,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_reqcyc,
  input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0] req_req,
  input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]  req_reqtag,
  output logic [NUM_REQ-1:0]                req_reqack,
  input  logic [NUM_REQ-1:0]                req_respack,
  output logic                              bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]         bus_req,
  output logic [BUS_TAG_WIDTH-1:0]          bus_reqtag,
  input  logic                              bus_reqack,
  output logic                              bus_respack,
  output logic                              grant_valid,
  output logic [ID_W-1:0]                   grant_id
`ifdef ARB_GRANT_STATS_EN
  ,
  input  logic [ID_W-1:0]                   stat_sel,
  output logic [31:0]                       stat_count
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [ID_W-1:0] r_owner, r_last;
  logic [ID_W-1:0] w_owner_nxt, w_last_nxt;
  logic            w_owner_active;
  logic            w_arb_found;
  logic [ID_W-1:0] w_arb_id;
  logic            w_sel_valid;
  logic [ID_W-1:0] w_sel_id;
  logic            w_new_grant;

  // In BUSY r_last always equals r_owner, so one scan serves both IDLE and re-arbitration.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] w_idx;
    w_arb_found = 1'b0;
    w_arb_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(r_last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      w_idx = ID_W'(idx);
      if (!w_arb_found && req_reqcyc[w_idx]) begin
        w_arb_found = 1'b1;
        w_arb_id    = w_idx;
      end
    end
  end

  assign w_owner_active = (r_state == BUSY) && req_reqcyc[r_owner];
  assign w_new_grant    = !w_owner_active && w_arb_found;
  assign w_sel_valid    = w_owner_active || w_arb_found;
  assign w_sel_id       = w_owner_active ? r_owner : w_arb_id;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_state_nxt = IDLE;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    unique case (r_state)
      IDLE: begin
        if (w_arb_found) begin
          w_state_nxt = BUSY;
          w_owner_nxt = w_arb_id;
          w_last_nxt  = w_arb_id;
        end
      end
      BUSY: begin
        if (w_owner_active) begin
          w_state_nxt = BUSY;
        end else if (w_arb_found) begin
          w_state_nxt = BUSY;
          w_owner_nxt = w_arb_id;
          w_last_nxt  = w_arb_id;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Outputs are forced low while reset is held, abandoning any in-flight beat.
  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    req_reqack  = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    bus_respack = 1'b0;
    if (!reset) begin
      bus_respack = |req_respack;
      if (w_sel_valid) begin
        bus_reqcyc           = 1'b1;
        bus_req              = req_req[w_sel_id*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        bus_reqtag           = req_reqtag[w_sel_id*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
        req_reqack[w_sel_id] = bus_reqack;
        grant_valid          = 1'b1;
        grant_id             = w_sel_id;
      end
    end
  end

`ifdef ARB_GRANT_STATS_EN
  logic [31:0] r_stat_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    // NOTE: this array is a handful of counters that must read zero after reset, so it is reset explicitly; RAM-like storage normally is not.
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat_cnt[i] <= '0;
    end else if (w_new_grant) begin
      r_stat_cnt[w_arb_id] <= r_stat_cnt[w_arb_id] + 32'd1;
    end
  end

  always_comb begin
    stat_count = '0;
    if (int'(stat_sel) < NUM_REQ) stat_count = r_stat_cnt[stat_sel];
  end
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (NUM_REQ=3): directed vector table, random
// stimulus against a behavioural round-robin model, and ARB_GRANT_STATS_EN counter checks.
module tb_bus_arbiter_rr;
  localparam int N = 3;
  localparam int W = 64;
  localparam int T = 13;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_reqcyc;
  logic [N*W-1:0]   req_req;
  logic [N*T-1:0]   req_reqtag;
  logic [N-1:0]     req_reqack;
  logic [N-1:0]     req_respack;
  logic             bus_reqcyc;
  logic [W-1:0]     bus_req;
  logic [T-1:0]     bus_reqtag;
  logic             bus_reqack;
  logic             bus_respack;
  logic             grant_valid;
  logic [1:0]       grant_id;
`ifdef ARB_GRANT_STATS_EN
  logic [1:0]       stat_sel = 2'd0;
  logic [31:0]      stat_count;
`endif

  bus_arbiter_rr #(.NUM_REQ(N), .BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_reqcyc  (req_reqcyc),
    .req_req     (req_req),
    .req_reqtag  (req_reqtag),
    .req_reqack  (req_reqack),
    .req_respack (req_respack),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respack (bus_respack),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
`ifdef ARB_GRANT_STATS_EN
    ,
    .stat_sel    (stat_sel),
    .stat_count  (stat_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: current owner (-1 = none), round-robin pointer, per-requester data and grant counts.
  int          m_owner = -1;
  int          m_last  = N - 1;
  logic [W-1:0] m_data [N];
  logic [T-1:0] m_tag  [N];
  logic [31:0]  m_cnt  [N];
  int          m_sel;
  bit          m_newg;

  function automatic int model_pick(output bit newg);
    newg = 1'b0;
    if (m_owner >= 0 && req_reqcyc[m_owner]) return m_owner;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req_reqcyc[i]) begin
        newg = 1'b1;
        return i;
      end
    end
    return -1;
  endfunction

  task automatic pack_data();
    for (int i = 0; i < N; i++) begin
      req_req[i*W +: W]    = m_data[i];
      req_reqtag[i*T +: T] = m_tag[i];
    end
  endtask

  // Drive inputs just after a rising edge, then compare mid-cycle against the model.
  task automatic apply_and_check(input logic rst, input logic [N-1:0] cyc,
                                 input logic ack, input logic [N-1:0] rsp);
    logic [N-1:0] e_ack;
    logic         e_gv;
    logic [1:0]   e_gid;
    logic [W-1:0] e_data;
    logic [T-1:0] e_tag;
    reset       = rst;
    req_reqcyc  = cyc;
    bus_reqack  = ack;
    req_respack = rsp;
    pack_data();
    #3;
    m_sel  = model_pick(m_newg);
    e_ack  = '0;
    e_gv   = 1'b0;
    e_gid  = '0;
    e_data = '0;
    e_tag  = '0;
    if (!rst && m_sel >= 0) begin
      e_gv         = 1'b1;
      e_gid        = 2'(m_sel);
      e_data       = m_data[m_sel];
      e_tag        = m_tag[m_sel];
      e_ack[m_sel] = ack;
    end
    check("bus_reqcyc",  64'(bus_reqcyc),  64'(e_gv));
    check("grant_valid", 64'(grant_valid), 64'(e_gv));
    check("grant_id",    64'(grant_id),    64'(e_gid));
    check("bus_req",     64'(bus_req),     64'(e_data));
    check("bus_reqtag",  64'(bus_reqtag),  64'(e_tag));
    check("req_reqack",  64'(req_reqack),  64'(e_ack));
    check("bus_respack", 64'(bus_respack), 64'(!rst && (|rsp)));
`ifdef ARB_GRANT_STATS_EN
    check("stat_count",  64'(stat_count),  64'(m_cnt[stat_sel]));
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      m_owner = -1;
      m_last  = N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
    end else begin
      if (m_newg && m_sel >= 0) begin
        m_last       = m_sel;
        m_cnt[m_sel] = m_cnt[m_sel] + 32'd1;
      end
      m_owner = m_sel;
    end
    #1;
  endtask

  task automatic step(input logic rst, input logic [N-1:0] cyc,
                      input logic ack, input logic [N-1:0] rsp);
    apply_and_check(rst, cyc, ack, rsp);
    advance();
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] cyc;
    logic         ack;
    logic [N-1:0] rsp;
    logic         e_gv;
    logic [1:0]   e_gid;
    logic [N-1:0] e_ack;
    logic         e_rsp;
  } vec_t;

  vec_t vecs [25];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_data[i] = {32'hC0DE_0000, 32'(i)};
      m_tag[i]  = T'(13'h100 + i);
      m_cnt[i]  = '0;
    end
    m_data[1] = 64'hA5;
    m_tag[1]  = 13'h12;

    // Directed sequence: single requester, simultaneous rise, multi-beat lock, reset mid-beat, response path.
    vecs[0]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0};
    vecs[1]  = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b1, 2'd1, 3'b000, 1'b0};
    vecs[2]  = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b1, 2'd1, 3'b000, 1'b0};
    vecs[3]  = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b1, 2'd1, 3'b000, 1'b0};
    vecs[4]  = '{1'b0, 3'b010, 1'b1, 3'b000, 1'b1, 2'd1, 3'b010, 1'b0};
    vecs[5]  = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0};
    vecs[6]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0};
    vecs[7]  = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b1, 2'd0, 3'b001, 1'b0};
    vecs[8]  = '{1'b0, 3'b110, 1'b1, 3'b000, 1'b1, 2'd1, 3'b010, 1'b0};
    vecs[9]  = '{1'b0, 3'b100, 1'b1, 3'b000, 1'b1, 2'd2, 3'b100, 1'b0};
    vecs[10] = '{1'b0, 3'b011, 1'b1, 3'b000, 1'b1, 2'd0, 3'b001, 1'b0};
    vecs[11] = '{1'b0, 3'b110, 1'b1, 3'b000, 1'b1, 2'd1, 3'b010, 1'b0};
    vecs[12] = '{1'b0, 3'b100, 1'b1, 3'b000, 1'b1, 2'd2, 3'b100, 1'b0};
    vecs[13] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0};
    vecs[14] = '{1'b0, 3'b011, 1'b1, 3'b000, 1'b1, 2'd0, 3'b001, 1'b0};
    vecs[15] = '{1'b0, 3'b011, 1'b1, 3'b000, 1'b1, 2'd0, 3'b001, 1'b0};
    vecs[16] = '{1'b0, 3'b011, 1'b1, 3'b000, 1'b1, 2'd0, 3'b001, 1'b0};
    vecs[17] = '{1'b0, 3'b011, 1'b1, 3'b000, 1'b1, 2'd0, 3'b001, 1'b0};
    vecs[18] = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b1, 2'd1, 3'b000, 1'b0};
    vecs[19] = '{1'b0, 3'b010, 1'b1, 3'b000, 1'b1, 2'd1, 3'b010, 1'b0};
    vecs[20] = '{1'b0, 3'b100, 1'b0, 3'b000, 1'b1, 2'd2, 3'b000, 1'b0};
    vecs[21] = '{1'b1, 3'b101, 1'b1, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0};
    vecs[22] = '{1'b0, 3'b101, 1'b0, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0};
    vecs[23] = '{1'b0, 3'b101, 1'b0, 3'b100, 1'b1, 2'd0, 3'b000, 1'b1};
    vecs[24] = '{1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0};

    #1;
    for (int v = 0; v < 25; v++) begin
      apply_and_check(vecs[v].rst, vecs[v].cyc, vecs[v].ack, vecs[v].rsp);
      check($sformatf("vec%0d_grant_valid", v), 64'(grant_valid), 64'(vecs[v].e_gv));
      check($sformatf("vec%0d_grant_id", v),    64'(grant_id),    64'(vecs[v].e_gid));
      check($sformatf("vec%0d_reqack", v),      64'(req_reqack),  64'(vecs[v].e_ack));
      check($sformatf("vec%0d_respack", v),     64'(bus_respack), 64'(vecs[v].e_rsp));
      if (v == 1) begin
        check("single_bus_req", bus_req, 64'hA5);
        check("single_bus_tag", 64'(bus_reqtag), 64'h12);
      end
      advance();
    end

    // Random traffic: owners tend to hold for several cycles so multi-beat locking is exercised.
    for (int c = 0; c < 500; c++) begin
      logic [N-1:0] cyc;
      cyc = N'($urandom);
      if ($urandom_range(0, 2) != 0 && m_owner >= 0) cyc[m_owner] = 1'b1;
      for (int i = 0; i < N; i++) begin
        m_data[i] = {$urandom, $urandom};
        m_tag[i]  = T'($urandom);
      end
`ifdef ARB_GRANT_STATS_EN
      stat_sel = 2'($urandom_range(0, N - 1));
`endif
      step($urandom_range(0, 39) == 0, cyc, 1'($urandom), N'($urandom));
    end

`ifdef ARB_GRANT_STATS_EN
    // Five fresh grants to requester 1, two to requester 0, then read both counters and clear.
    step(1'b1, 3'b000, 1'b0, 3'b000);
    for (int g = 0; g < 5; g++) begin
      step(1'b0, 3'b010, 1'b1, 3'b000);
      step(1'b0, 3'b000, 1'b0, 3'b000);
    end
    for (int g = 0; g < 2; g++) begin
      step(1'b0, 3'b001, 1'b1, 3'b000);
      step(1'b0, 3'b000, 1'b0, 3'b000);
    end
    stat_sel = 2'd1;
    #2;
    check("stat_req1_five", 64'(stat_count), 64'd5);
    stat_sel = 2'd0;
    #1;
    check("stat_req0_two", 64'(stat_count), 64'd2);
    step(1'b1, 3'b000, 1'b0, 3'b000);
    reset = 1'b0;
    #2;
    check("stat_req0_cleared", 64'(stat_count), 64'd0);
    stat_sel = 2'd1;
    #1;
    check("stat_req1_cleared", 64'(stat_count), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
